// File: rtl/mem_responder.sv
// Responder side of the CPU memory port: request/ready handshake with programmable
// wait states in front of a unified RAM plus a small LED / cycle-counter I/O region.
module mem_responder #(
   parameter int          ADDR_WIDTH  = 6,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] IO_LED_ADDR = 32'h0000_FF00,
   parameter logic [31:0] IO_CNT_ADDR = 32'h0000_FF04,
   parameter string       MEM_FILE    = ""
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        memreq,
   input  logic        memwrite,
   input  logic [31:0] adr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        memready,
   output logic [7:0]  led,
   output logic        addr_err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] DEC_RAM = 2'd0;
   localparam logic [1:0] DEC_LED = 2'd1;
   localparam logic [1:0] DEC_CNT = 2'd2;
   localparam logic [1:0] DEC_ERR = 2'd3;

   // Alignment is checked before the I/O match so a misaligned I/O address is an error.
   function automatic logic [1:0] decode(input logic [31:0] a);
      logic [1:0] d;
      if (a[1:0] != 2'b00) begin
         d = DEC_ERR;
      end else if (a == IO_LED_ADDR) begin
         d = DEC_LED;
      end else if (a == IO_CNT_ADDR) begin
         d = DEC_CNT;
      end else if ((a >> (ADDR_WIDTH + 2)) == 32'd0) begin
         d = DEC_RAM;
      end else begin
         d = DEC_ERR;
      end
      return d;
   endfunction

   logic [1:0]            state_r;
   logic [1:0]            state_nx_s;
   logic [3:0]            wcnt_r;
   logic [31:0]           adr_r;
   logic [31:0]           wdata_r;
   logic                  we_r;
   logic [31:0]           readdata_r;
   logic                  memready_r;
   logic [7:0]            led_r;
   logic [31:0]           cnt_r;
   logic                  addr_err_r;
   logic [31:0]           mem_r [DEPTH];
   logic [1:0]            dec_s;
   logic [ADDR_WIDTH-1:0] widx_s;
   logic                  commit_s;
   logic                  accept_s;

   assign accept_s = (state_r == ST_IDLE) && memreq;
   assign commit_s = (state_r == ST_BUSY) && (wcnt_r == 4'd0);
   assign dec_s    = decode(adr_r);
   assign widx_s   = adr_r[ADDR_WIDTH+1:2];

   assign readdata = readdata_r;
   assign memready = memready_r;
   assign led      = led_r;
   assign addr_err = addr_err_r;

   // Next-state logic of the IDLE/BUSY/RESP handshake FSM.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (memreq) state_nx_s = ST_BUSY;
            else        state_nx_s = ST_IDLE;
         end
         ST_BUSY: begin
            if (wcnt_r == 4'd0) state_nx_s = ST_RESP;
            else                state_nx_s = ST_BUSY;
         end
         ST_RESP: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register, wait counter and request capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         wcnt_r  <= 4'd0;
         adr_r   <= 32'd0;
         wdata_r <= 32'd0;
         we_r    <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         if (accept_s) begin
            wcnt_r  <= 4'(WAIT_CYCLES);
            adr_r   <= adr;
            wdata_r <= writedata;
            we_r    <= memwrite;
         end else if ((state_r == ST_BUSY) && (wcnt_r != 4'd0)) begin
            wcnt_r <= wcnt_r - 4'd1;
         end else begin
            wcnt_r <= wcnt_r;
         end
      end
   end

   // Access effects land on the RESP-entry edge; the counter runs every cycle otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_r <= 32'd0;
         memready_r <= 1'b0;
         led_r      <= 8'd0;
         cnt_r      <= 32'd0;
         addr_err_r <= 1'b0;
      end else begin
         memready_r <= commit_s;
         if (commit_s && we_r && (dec_s == DEC_CNT)) cnt_r <= wdata_r;
         else                                        cnt_r <= cnt_r + 32'd1;
         if (commit_s) begin
            case (dec_s)
               DEC_RAM: begin
                  if (!we_r) readdata_r <= mem_r[widx_s];
               end
               DEC_LED: begin
                  if (we_r) led_r      <= wdata_r[7:0];
                  else      readdata_r <= {24'd0, led_r};
               end
               DEC_CNT: begin
                  if (!we_r) readdata_r <= cnt_r;
               end
               DEC_ERR: begin
                  readdata_r <= 32'd0;
                  addr_err_r <= 1'b1;
               end
               default: begin
                  readdata_r <= 32'd0;
                  addr_err_r <= 1'b1;
               end
            endcase
         end
      end
   end

   // Storage array; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (commit_s && we_r && (dec_s == DEC_RAM)) begin
         mem_r[widx_s] <= wdata_r;
      end
   end

endmodule
